// File: rtl/edn_share_pkg.sv
// Shared types and constants for the EDN endpoint sharing arbiter.
package edn_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } edn_share_state_e;

    localparam int DropCntW = 16;
    localparam logic [DropCntW-1:0] DropCntMax = '1;

endpackage

// File: rtl/edn_share_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module edn_share_rr_arb
    import edn_share_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int ReqIdxW = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  req_i,
    input  logic [ReqIdxW-1:0] ptr_i,
    output logic [ReqIdxW-1:0] idx_o,
    output logic               vld_o
);

    int                 cand;
    logic [ReqIdxW-1:0] cand_idx;

    // Scan from the farthest candidate down so the nearest one to ptr_i wins last.
    always_comb begin
        idx_o    = '0;
        vld_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand     = (int'(ptr_i) + i) % NumReq;
            cand_idx = cand[ReqIdxW-1:0];
            if (req_i[cand_idx]) begin
                idx_o = cand_idx;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/edn_ep_share.sv
// Round-robin sharing of one EDN endpoint among NumReq consumers.
// Optional one-word prefetch buffer enabled by defining EDN_SHARE_PREFETCH_EN.
module edn_ep_share
    import edn_share_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int ReqIdxW = $clog2(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [NumReq-1:0]   req_i,
    output logic [NumReq-1:0]   ack_o,
    output logic [31:0]         bus_o,
    output logic                fips_o,
    output logic                edn_req_o,
    input  logic                edn_ack_i,
    input  logic                edn_fips_i,
    input  logic [31:0]         edn_bus_i,
    output logic                busy_o,
    output logic [ReqIdxW-1:0]  grant_idx_o,
    output logic [DropCntW-1:0] drop_cnt_o
);

    localparam logic [NumReq-1:0] OneHot0 = NumReq'(1);

    function automatic logic [DropCntW-1:0] sat_inc(input logic [DropCntW-1:0] v);
        return (v == DropCntMax) ? v : v + DropCntW'(1);
    endfunction

    function automatic logic [ReqIdxW-1:0] next_ptr(input logic [ReqIdxW-1:0] g);
        return (g == ReqIdxW'(NumReq - 1)) ? '0 : g + ReqIdxW'(1);
    endfunction

    edn_share_state_e    state_q;
    logic [ReqIdxW-1:0]  rr_ptr_q;
    logic [ReqIdxW-1:0]  grant_q;
    logic [NumReq-1:0]   ack_q;
    logic [31:0]         bus_q;
    logic                fips_q;
    logic                edn_req_q;
    logic [DropCntW-1:0] drop_cnt_q;
    logic [DropCntW-1:0] drop_cnt_d;
    logic [ReqIdxW-1:0]  win_idx;
    logic                win_vld;

`ifdef EDN_SHARE_PREFETCH_EN
    logic        buf_vld;
    logic [31:0] buf_word;
    logic        buf_fips;
    logic        pf_q;
    logic        srv_pend_q;
`endif

    assign drop_cnt_d = sat_inc(drop_cnt_q);

    edn_share_rr_arb #(
        .NumReq  (NumReq),
        .ReqIdxW (ReqIdxW)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            bus_q      <= '0;
            fips_q     <= 1'b0;
            edn_req_q  <= 1'b0;
            drop_cnt_q <= '0;
`ifdef EDN_SHARE_PREFETCH_EN
            buf_vld    <= 1'b0;
            pf_q       <= 1'b0;
            srv_pend_q <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
`ifdef EDN_SHARE_PREFETCH_EN
                    if (enable_i && win_vld && buf_vld) begin
                        grant_q    <= win_idx;
                        srv_pend_q <= 1'b1;
                        state_q    <= RESP;
                    end else if (enable_i && win_vld) begin
                        grant_q   <= win_idx;
                        edn_req_q <= 1'b1;
                        state_q   <= REQ;
                    end else if (enable_i && !buf_vld) begin
                        pf_q      <= 1'b1;
                        edn_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
`else
                    if (enable_i && win_vld) begin
                        grant_q   <= win_idx;
                        edn_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
`endif
                end
                REQ: begin
                    // The upstream request is only released by the upstream ack.
                    if (edn_ack_i) begin
                        edn_req_q <= 1'b0;
                        state_q   <= RESP;
`ifdef EDN_SHARE_PREFETCH_EN
                        if (pf_q) begin
                            buf_word <= edn_bus_i;
                            buf_fips <= edn_fips_i;
                            buf_vld  <= 1'b1;
                        end else
`endif
                        if (req_i[grant_q]) begin
                            ack_q  <= OneHot0 << grant_q;
                            bus_q  <= edn_bus_i;
                            fips_q <= edn_fips_i;
                        end
`ifdef EDN_SHARE_PREFETCH_EN
                        else if (!buf_vld) begin
                            buf_word <= edn_bus_i;
                            buf_fips <= edn_fips_i;
                            buf_vld  <= 1'b1;
                        end
`endif
                        else begin
                            drop_cnt_q <= drop_cnt_d;
                        end
                    end
                end
                RESP: begin
`ifdef EDN_SHARE_PREFETCH_EN
                    // A buffered grant spends one RESP cycle deciding, then one acking.
                    if (srv_pend_q) begin
                        srv_pend_q <= 1'b0;
                        if (req_i[grant_q]) begin
                            ack_q   <= OneHot0 << grant_q;
                            bus_q   <= buf_word;
                            fips_q  <= buf_fips;
                            buf_vld <= 1'b0;
                        end
                    end else begin
                        if (!pf_q) begin
                            rr_ptr_q <= next_ptr(grant_q);
                        end
                        pf_q    <= 1'b0;
                        state_q <= IDLE;
                    end
`else
                    rr_ptr_q <= next_ptr(grant_q);
                    state_q  <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign bus_o       = bus_q;
    assign fips_o      = fips_q;
    assign edn_req_o   = edn_req_q;
    assign busy_o      = (state_q != IDLE);
    assign grant_idx_o = grant_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_edn_ep_share.sv
// Directed self-checking bench for edn_ep_share (default and prefetch builds).
module tb_edn_ep_share;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [3:0]  req_i;
    logic [3:0]  ack_o;
    logic [31:0] bus_o;
    logic        fips_o;
    logic        edn_req_o;
    logic        edn_ack_i;
    logic        edn_fips_i;
    logic [31:0] edn_bus_i;
    logic        busy_o;
    logic [1:0]  grant_idx_o;
    logic [15:0] drop_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    edn_ep_share #(.NumReq(4), .ReqIdxW(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .req_i       (req_i),
        .ack_o       (ack_o),
        .bus_o       (bus_o),
        .fips_o      (fips_o),
        .edn_req_o   (edn_req_o),
        .edn_ack_i   (edn_ack_i),
        .edn_fips_i  (edn_fips_i),
        .edn_bus_i   (edn_bus_i),
        .busy_o      (busy_o),
        .grant_idx_o (grant_idx_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_edn_req();
        int n = 0;
        while (edn_req_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (edn_req_o !== 1'b1) chk("edn_req_wait", edn_req_o, 1);
    endtask

    // Upstream model: answer the pending request after wait_cyc extra cycles.
    task automatic upstream(input int wait_cyc, input logic [31:0] w, input logic f);
        wait_edn_req();
        repeat (wait_cyc) @(negedge clk);
        edn_ack_i  = 1'b1;
        edn_bus_i  = w;
        edn_fips_i = f;
        @(negedge clk);
        edn_ack_i  = 1'b0;
    endtask

    task automatic withdraw(input logic [3:0] who);
        req_i = who;
        wait_edn_req();
        req_i     = 4'b0000;
        edn_ack_i = 1'b1;
        edn_bus_i = 32'h0BAD_F00D;
        @(negedge clk);
        edn_ack_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"},   ack_o, 4'b0000);
        chk({tag, "_ereq"},  edn_req_o, 1'b0);
        chk({tag, "_bus"},   bus_o, 32'h0);
        chk({tag, "_fips"},  fips_o, 1'b0);
        chk({tag, "_busy"},  busy_o, 1'b0);
        chk({tag, "_grant"}, grant_idx_o, 2'd0);
        chk({tag, "_drop"},  drop_cnt_o, 16'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b1;
        req_i      = 4'b0000;
        edn_ack_i  = 1'b0;
        edn_fips_i = 1'b0;
        edn_bus_i  = 32'h0;
`ifdef EDN_SHARE_PREFETCH_EN
        enable_i = 1'b0;
`else
        enable_i = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_i = 1'b0;
        @(negedge clk);

`ifndef EDN_SHARE_PREFETCH_EN
        // Single requester, upstream answers two cycles after edn_req_o rises.
        req_i = 4'b0001;
        @(negedge clk);
        chk("single_ereq", edn_req_o, 1'b1);
        chk("single_grant", grant_idx_o, 2'd0);
        chk("single_busy", busy_o, 1'b1);
        upstream(1, 32'h2222_18A5, 1'b1);
        chk("single_ack", ack_o, 4'b0001);
        chk("single_bus", bus_o, 32'h2222_18A5);
        chk("single_fips", fips_o, 1'b1);
        req_i = 4'b0000;
        @(negedge clk);
        chk("single_ack_once", ack_o, 4'b0000);
        chk("single_idle", busy_o, 1'b0);

        // Reset during a fetch.
        req_i = 4'b0001;
        wait_edn_req();
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        req_i = 4'b0000;
        chk_reset_vals("midrst");

        // Stray upstream ack while idle.
        edn_ack_i = 1'b1;
        edn_bus_i = 32'hDEAD_BEEF;
        @(negedge clk);
        edn_ack_i = 1'b0;
        chk("stray_busy", busy_o, 1'b0);
        chk("stray_ack", ack_o, 4'b0000);
        chk("stray_bus", bus_o, 32'h0);

        // Fairness with 0, 1 and 3 streaming.
        begin
            int order [6] = '{0, 1, 3, 0, 1, 3};
            logic [3:0] oh;
            req_i = 4'b1011;
            for (int i = 0; i < 6; i++) begin
                upstream(0, 32'hA000_0000 + i, i[0]);
                oh = 4'b0001 << order[i];
                chk("fair_ack", ack_o, oh);
                chk("fair_grant", grant_idx_o, order[i]);
                chk("fair_bus", bus_o, 32'hA000_0000 + i);
            end
            req_i = 4'b0000;
            @(negedge clk);
        end

        // Requester 2 withdraws while its word is in flight.
        req_i = 4'b0100;
        wait_edn_req();
        chk("wd_grant", grant_idx_o, 2'd2);
        req_i      = 4'b1001;
        edn_ack_i  = 1'b1;
        edn_bus_i  = 32'h5555_5555;
        edn_fips_i = 1'b0;
        @(negedge clk);
        edn_ack_i = 1'b0;
        chk("wd_noack", ack_o, 4'b0000);
        chk("wd_drop", drop_cnt_o, 16'd1);
        chk("wd_bus_hold", bus_o, 32'hA000_0005);
        upstream(0, 32'h3333_0003, 1'b0);
        chk("wd_next_ack", ack_o, 4'b1000);
        chk("wd_next_grant", grant_idx_o, 2'd3);
        req_i = 4'b0001;
        upstream(0, 32'h3333_0000, 1'b1);
        chk("wd_then0_ack", ack_o, 4'b0001);
        req_i = 4'b0000;
        @(negedge clk);

        // enable_i gates new grants only.
        enable_i = 1'b0;
        req_i    = 4'b0001;
        repeat (3) @(negedge clk);
        chk("en_low_busy", busy_o, 1'b0);
        chk("en_low_ereq", edn_req_o, 1'b0);
        enable_i = 1'b1;
        wait_edn_req();
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("en_fall_ereq_held", edn_req_o, 1'b1);
        upstream(0, 32'h4444_4444, 1'b0);
        chk("en_fall_ack", ack_o, 4'b0001);
        chk("en_fall_bus", bus_o, 32'h4444_4444);
        req_i    = 4'b0000;
        enable_i = 1'b1;
        @(negedge clk);

        // Saturation: preload near the top, then withdraw twice.
        force dut.drop_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.drop_cnt_q;
        withdraw(4'b0010);
        chk("sat_reach", drop_cnt_o, 16'hFFFF);
        withdraw(4'b0010);
        chk("sat_hold", drop_cnt_o, 16'hFFFF);
        chk("sat_noack", ack_o, 4'b0000);
`else
        // Idle with enable: one prefetch into the buffer, no ack.
        enable_i = 1'b1;
        @(negedge clk);
        chk("pf_ereq", edn_req_o, 1'b1);
        chk("pf_busy", busy_o, 1'b1);
        chk("pf_grant", grant_idx_o, 2'd0);
        edn_ack_i  = 1'b1;
        edn_bus_i  = 32'hE7EE_1E47;
        edn_fips_i = 1'b1;
        @(negedge clk);
        edn_ack_i = 1'b0;
        chk("pf_noack", ack_o, 4'b0000);
        chk("pf_bus_unchanged", bus_o, 32'h0);
        repeat (2) @(negedge clk);
        chk("pf_full_idle", busy_o, 1'b0);
        chk("pf_full_noreq", edn_req_o, 1'b0);

        // Buffered grant for requester 1.
        req_i = 4'b0010;
        @(negedge clk);
        chk("pfg_grant", grant_idx_o, 2'd1);
        chk("pfg_ack_early", ack_o, 4'b0000);
        chk("pfg_noereq", edn_req_o, 1'b0);
        @(negedge clk);
        chk("pfg_ack", ack_o, 4'b0010);
        chk("pfg_bus", bus_o, 32'hE7EE_1E47);
        chk("pfg_fips", fips_o, 1'b1);
        req_i = 4'b0000;
        @(negedge clk);
        chk("pfg_ack_once", ack_o, 4'b0000);
        @(negedge clk);
        chk("pfg_refill", edn_req_o, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/edn_ep_share.md
# edn_ep_share

Round-robin arbiter that lets `NumReq` entropy consumers share one EDN endpoint port. It sits between a single `edn` endpoint (`edn_req_t`/`edn_rsp_t` pair) and several peripheral consumers. It serialises their word requests and routes each 32-bit response, with its FIPS flag, back to the requester that was granted. It also counts words fetched on behalf of requesters that withdrew before delivery.

## Interface
Parameters:
- `NumReq`, 4, number of sharing consumers (2..8)
- `ReqIdxW`, `$clog2(NumReq)`, width of grant index

Ports:
- `clk_i` in 1: clock
- `rst_i` in 1: synchronous, active-high reset
- `enable_i` in 1: permits new grants; an in-flight fetch always completes
- `req_i` in NumReq: per-consumer request, level, held until `ack_o`
- `ack_o` out NumReq: per-consumer one-cycle ack, one-hot or zero
- `bus_o` out 32: response word, valid when any `ack_o` bit is set
- `fips_o` out 1: FIPS flag of `bus_o`
- `edn_req_o` out 1: upstream request (maps to `edn_req_t.edn_req`)
- `edn_ack_i` in 1: upstream ack
- `edn_fips_i` in 1: upstream FIPS flag
- `edn_bus_i` in 32: upstream word
- `busy_o` out 1: state is not IDLE
- `grant_idx_o` out ReqIdxW: current/last winner
- `drop_cnt_o` out 16: saturating count of discarded words

## Operation
- FSM states are IDLE, REQ and RESP. State and all outputs are registered.
- IDLE:
  - Transition: if `enable_i` and any `req_i` bit is set → REQ. The winner is the first set bit searching upward, with wrap, from `rr_ptr`. Latch the winner into `grant_idx_o`.
  - Outputs: `edn_req_o`=0.
- REQ:
  - Outputs: `edn_req_o`=1, held until `edn_ack_i`. It never drops early, including when the winner deasserts or `enable_i` falls.
  - Transition: on `edn_ack_i`, capture `edn_bus_i`/`edn_fips_i` into the data regs → RESP.
- RESP:
  - If `req_i[grant_idx_o]`=1: `ack_o[grant_idx_o]`=1 for this cycle, with `bus_o`/`fips_o` from the data regs.
  - Otherwise: no ack; `drop_cnt_o` += 1, saturating at 0xFFFF.
  - `rr_ptr` ← `grant_idx_o`+1, mod NumReq. Always → IDLE.
- `bus_o`/`fips_o` hold their last value between acks. Consumers must qualify them with `ack_o`.
- A requester may keep `req_i` high across acks to stream words. Round-robin then gives every other pending requester one word before it is served again.
- Reset values: state IDLE, `rr_ptr`=0, `ack_o`=0, `edn_req_o`=0, `bus_o`=0, `fips_o`=0, `busy_o`=0, `grant_idx_o`=0, `drop_cnt_o`=0.

## Timing
- Request to upstream request:
  - `req_i[k]` is sampled high in IDLE at cycle t.
  - `edn_req_o`=1 and `grant_idx_o`=k from t+1.
- Upstream ack to consumer ack:
  - `edn_ack_i` sampled at cycle m.
  - `ack_o[k]`=1 in cycle m+1 only.
  - IDLE at m+2; the next grant is sampled at m+2, so `edn_req_o` rises at m+3.
- Minimum spacing between acks is 3 cycles plus upstream latency.
- `edn_ack_i` while not in REQ is ignored (protocol violation; no state change).
- Reset asserted mid-fetch: `edn_req_o` is 0 in the cycle after reset is sampled, and the captured word is lost (not counted).
- `enable_i` falling has no effect on REQ/RESP. IDLE stays IDLE while it is low.

## Configuration
- `EDN_SHARE_PREFETCH_EN` defined: adds a one-word buffer (`buf_vld`, `buf_word`, `buf_fips`).
  - Prefetch fetch: in IDLE with `buf_vld`=0, `enable_i`=1 and no `req_i` set → REQ as a prefetch. No winner is recorded, and the word is written to the buffer in RESP with no ack.
  - Buffered grant: in IDLE with `buf_vld`=1 and a request pending → go directly to RESP for the winner, serving the buffer word and clearing `buf_vld`. The request-to-ack latency is 2 cycles.
  - Dropped word: if the winner withdrew in RESP and `buf_vld`=0, the word goes to the buffer instead of being counted.
  - Reset clears `buf_vld`.
- Undefined: no buffer, fetch only on demand, behaviour exactly as above.

## Structure
- `edn_share_pkg`: `edn_share_state_e` (IDLE/REQ/RESP), `DropCntW`=16, `DropCntMax`.
- Sub-module `edn_share_rr_arb`: combinational round-robin pick from `req_i` and `rr_ptr`, outputting the winner index and an any-valid flag. The FSM and data regs stay in the top.

## Test plan
- Single requester: `req_i`=4'b0001, upstream acks 2 cycles after `edn_req_o` with 0x222218A5 and fips=1 → `ack_o`=4'b0001 one cycle later, `bus_o`=0x222218A5, `fips_o`=1.
- Fairness: `req_i`=4'b1011 held high for 6 words → grant order 0,1,3,0,1,3. `grant_idx_o` matches each ack.
- Withdrawal: requester 2 drops `req_i` while in REQ → no `ack_o`, `drop_cnt_o`=1. Next grant goes to the next pending requester after 2.
- Saturation: force 65536 withdrawals → `drop_cnt_o` stays at 0xFFFF.
- Reset mid-REQ: assert `rst_i` for one cycle → `edn_req_o`=0 the next cycle, all outputs at reset values, `drop_cnt_o` unchanged at 0.
- Prefetch (macro defined): idle with enable → one upstream fetch of 0xE7EE1E47 into the buffer. A later `req_i[1]` gets `ack_o[1]` two cycles later with `bus_o`=0xE7EE1E47, and a refill fetch starts.
